// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - control/status bundle for the loadable countdown timer
interface countdown_timer_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             auto_reload;
    logic             hold;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output load_val,
        output auto_reload,
        output hold,
        output abort,
        input  count,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  load_val,
        input  auto_reload,
        input  hold,
        input  abort,
        output count,
        output busy,
        output done
    );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with one-cycle done pulse and optional auto-reload
module countdown_timer #(
    parameter int WIDTH = 3
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  tmr
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // abort beats start beats hold; zero is handled explicitly so the count never wraps
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (tmr.abort) begin
            count_d = '0;
            state_d = IDLE;
        end else if (tmr.start) begin
            count_d  = tmr.load_val;
            reload_d = tmr.load_val;
            state_d  = RUN;
            done_d   = (tmr.load_val == '0);
        end else begin
            case (state_q)
                RUN: begin
                    if (!tmr.hold) begin
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else if (count_q == WIDTH'(1)) begin
                            count_d = '0;
                            done_d  = 1'b1;
                        end else if (tmr.auto_reload) begin
                            count_d = reload_q;
                            done_d  = (reload_q == '0);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign tmr.count = count_q;
    assign tmr.busy  = (state_q == RUN);
    assign tmr.done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer
module tb_countdown_timer;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    int   m_count;
    int   m_reload;
    bit   m_run;
    bit   m_done;

    countdown_timer_if #(.WIDTH(3)) tif ();

    countdown_timer #(.WIDTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .tmr   (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: remaining ticks until expiry, tracked as plain integers
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_count  <= 0;
            m_reload <= 0;
            m_run    <= 1'b0;
            m_done   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (tif.abort) begin
                m_count <= 0;
                m_run   <= 1'b0;
            end else if (tif.start) begin
                m_count  <= int'(tif.load_val);
                m_reload <= int'(tif.load_val);
                m_run    <= 1'b1;
                m_done   <= (tif.load_val == 3'd0);
            end else if (m_run && !tif.hold) begin
                if (m_count >= 2) begin
                    m_count <= m_count - 1;
                end else if (m_count == 1) begin
                    m_count <= 0;
                    m_done  <= 1'b1;
                end else if (tif.auto_reload) begin
                    m_count <= m_reload;
                    m_done  <= (m_reload == 0);
                end else begin
                    m_run <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model_count", int'(tif.count), m_count);
        chk("model_busy",  int'(tif.busy),  int'(m_run));
        chk("model_done",  int'(tif.done),  int'(m_done));
    endtask

    task automatic cyc(input bit s, input int lv, input bit ar, input bit h, input bit ab);
        tif.start       = s;
        tif.load_val    = 3'(lv);
        tif.auto_reload = ar;
        tif.hold        = h;
        tif.abort       = ab;
        @(negedge clk);
        compare_model();
    endtask

    task automatic expect_out(input string name, input int c, input int b, input int d);
        chk({name, "_count"}, int'(tif.count), c);
        chk({name, "_busy"},  int'(tif.busy),  b);
        chk({name, "_done"},  int'(tif.done),  d);
    endtask

    initial begin
        int exp_c[11];
        bit ar_sticky;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        tif.start = 1'b0; tif.load_val = '0; tif.auto_reload = 1'b0;
        tif.hold  = 1'b0; tif.abort    = 1'b0;
        #2;
        expect_out("reset", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0);
        expect_out("idle", 0, 0, 0);

        // one-shot load 5
        exp_c = '{5, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            cyc(i == 0, 5, 0, 0, 0);
            expect_out("oneshot5", exp_c[i], (i < 6) ? 1 : 0, (i == 5) ? 1 : 0);
        end

        // auto-reload 3: period of 4 with done on the zero cycle
        for (int i = 0; i < 12; i++) begin
            cyc(i == 0, 3, 1, 0, 0);
            expect_out("reload3", 3 - (i % 4), 1, (i % 4 == 3) ? 1 : 0);
        end
        cyc(0, 0, 1, 0, 1);
        expect_out("reload3_abort", 0, 0, 0);

        // load 6 with a 3-cycle hold at count 2
        exp_c = '{6, 5, 4, 3, 2, 2, 2, 2, 1, 0, 0};
        for (int i = 0; i < 11; i++) begin
            cyc(i == 0, 6, 0, (i >= 5 && i <= 7), 0);
            expect_out("hold6", exp_c[i], (i < 10) ? 1 : 0, (i == 9) ? 1 : 0);
        end

        // load zero one-shot
        cyc(1, 0, 0, 0, 0);
        expect_out("zero_first", 0, 1, 1);
        cyc(0, 0, 0, 0, 0);
        expect_out("zero_after", 0, 0, 0);

        // auto-reload zero: done every running cycle
        for (int i = 0; i < 4; i++) begin
            cyc(i == 0, 0, 1, 0, 0);
            expect_out("reload0", 0, 1, 1);
        end
        cyc(0, 0, 1, 1, 0);
        expect_out("reload0_hold", 0, 1, 0);
        cyc(0, 0, 0, 0, 1);

        // restart mid-run, then abort together with start
        cyc(1, 7, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        expect_out("restart_pre", 5, 1, 0);
        cyc(1, 4, 0, 0, 0);
        expect_out("restart", 4, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        expect_out("restart_cnt", 2, 1, 0);
        cyc(1, 6, 0, 0, 1);
        expect_out("abort_start", 0, 0, 0);

        // asynchronous reset between edges
        cyc(1, 5, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        expect_out("async_pre", 3, 1, 0);
        #2 reset = 1'b0;
        #1 expect_out("async_rst", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        expect_out("async_after", 0, 0, 0);

        // randomized traffic against the model
        ar_sticky = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) ar_sticky = ~ar_sticky;
            if ($urandom_range(0, 249) == 0) begin
                #($urandom_range(1, 4)) reset = 1'b0;
                #1 expect_out("rand_rst", 0, 0, 0);
                @(negedge clk);
                reset = 1'b1;
            end
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 7), ar_sticky,
                $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
